// File: rtl/mem_pkg.sv
// Shared constants, state encoding and strobe helper for the RV64 memory stage.
package mem_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [0:0] {IDLE, BUSY} state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational alignment helpers: misalign check and store lanes for the incoming op,
// load shift/extend for the op currently in flight.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]      req_size,
  input  logic [2:0]      req_addr_lo,
  input  logic [XLEN-1:0] req_sr2,
  output logic            req_misaligned,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wstrb,
  input  logic [2:0]      rsp_funct3,
  input  logic [2:0]      rsp_addr_lo,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] rsp_result
);

  logic [XLEN-1:0] ld_shift;
  logic            ld_signed;

  assign ld_shift  = rsp_rdata >> {rsp_addr_lo, 3'b000};
  assign ld_signed = ~rsp_funct3[2];

  always_comb begin
    unique case (req_size)
      SZ_B:    req_misaligned = 1'b0;
      SZ_H:    req_misaligned = req_addr_lo[0];
      SZ_W:    req_misaligned = |req_addr_lo[1:0];
      default: req_misaligned = |req_addr_lo;
    endcase
    req_wdata = req_sr2 << {req_addr_lo, 3'b000};
    req_wstrb = size_mask(req_size) << req_addr_lo;
  end

  always_comb begin
    unique case (rsp_funct3[1:0])
      SZ_B:    rsp_result = {{56{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    rsp_result = {{48{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      SZ_W:    rsp_result = {{32{ld_signed & ld_shift[31]}}, ld_shift[31:0]};
      default: rsp_result = ld_shift;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV64 memory-access stage: single-outstanding data-memory FSM plus the writeback
// pipeline registers and load/store fault flags.
module memory_stage
  import mem_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            MEM_V,
  input  logic [31:0]     MEM_IR,
  input  logic [XLEN-1:0] MEM_NPC,
  input  logic [XLEN-1:0] MEM_ALU_RESULT,
  input  logic [XLEN-1:0] MEM_SR2,
  input  logic            MEM_FLUSH,
  output logic            MEM_STALL,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  output logic [7:0]      DMEM_WSTRB,
  input  logic            DMEM_READY,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_ERR,
  output logic            WB_V,
  output logic [31:0]     WB_IR,
  output logic [XLEN-1:0] WB_NPC,
  output logic [XLEN-1:0] WB_ALU_RESULT,
  output logic [XLEN-1:0] WB_MEM_RESULT,
  output logic            MEM_LAM,
  output logic            MEM_LAF,
  output logic            MEM_SAM,
  output logic            MEM_SAF
);

  state_e          state_q, state_d;
  logic            kill_q, kill_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;

  logic            wb_v_q, wb_v_d;
  logic [31:0]     wb_ir_q, wb_ir_d;
  logic [XLEN-1:0] wb_npc_q, wb_npc_d;
  logic [XLEN-1:0] wb_alu_q, wb_alu_d;
  logic [XLEN-1:0] wb_mem_q, wb_mem_d;
  logic            lam_q, lam_d, laf_q, laf_d, sam_q, sam_d, saf_q, saf_d;

  logic            in_load, in_store, in_mem, in_valid;
  logic            q_load, q_store;
  logic            misaligned, accept, killed;
  logic [XLEN-1:0] lane_wdata, load_result;
  logic [7:0]      lane_wstrb;

  assign in_load  = (MEM_IR[6:0] == OP_LOAD);
  assign in_store = (MEM_IR[6:0] == OP_STORE);
  assign in_mem   = in_load | in_store;
  assign in_valid = MEM_V & ~MEM_FLUSH;
  assign accept   = in_valid & in_mem & ~misaligned;
  assign q_load   = (ir_q[6:0] == OP_LOAD);
  assign q_store  = (ir_q[6:0] == OP_STORE);
  // A flush arriving in the completion cycle kills the result just like an earlier one.
  assign killed   = kill_q | MEM_FLUSH;

  mem_align u_align (
    .req_size       (MEM_IR[13:12]),
    .req_addr_lo    (MEM_ALU_RESULT[2:0]),
    .req_sr2        (MEM_SR2),
    .req_misaligned (misaligned),
    .req_wdata      (lane_wdata),
    .req_wstrb      (lane_wstrb),
    .rsp_funct3     (ir_q[14:12]),
    .rsp_addr_lo    (addr_q[2:0]),
    .rsp_rdata      (DMEM_RDATA),
    .rsp_result     (load_result)
  );

  assign MEM_STALL  = ((state_q == IDLE) && accept) || ((state_q == BUSY) && !DMEM_READY);
  assign DMEM_REQ   = (state_q == BUSY);
  assign DMEM_WE    = q_store;
  assign DMEM_ADDR  = {addr_q[XLEN-1:3], 3'b000};
  assign DMEM_WDATA = wdata_q;
  assign DMEM_WSTRB = wstrb_q;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    ir_d     = ir_q;
    npc_d    = npc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wb_v_d   = wb_v_q;
    wb_ir_d  = wb_ir_q;
    wb_npc_d = wb_npc_q;
    wb_alu_d = wb_alu_q;
    wb_mem_d = wb_mem_q;
    lam_d    = lam_q;
    laf_d    = laf_q;
    sam_d    = sam_q;
    saf_d    = saf_q;

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        lam_d  = 1'b0;
        laf_d  = 1'b0;
        sam_d  = 1'b0;
        saf_d  = 1'b0;
        if (accept) begin
          state_d = BUSY;
          ir_d    = MEM_IR;
          npc_d   = MEM_NPC;
          addr_d  = MEM_ALU_RESULT;
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          wb_v_d  = 1'b0;
        end else begin
          // Pass-through: non-memory, idle, flushed or misaligned ops.
          wb_v_d   = in_valid;
          wb_ir_d  = MEM_IR;
          wb_npc_d = MEM_NPC;
          wb_alu_d = MEM_ALU_RESULT;
          wb_mem_d = '0;
          lam_d    = in_valid & in_load & misaligned;
          sam_d    = in_valid & in_store & misaligned;
        end
      end
      default: begin
        kill_d = killed;
        if (DMEM_READY) begin
          state_d  = IDLE;
          kill_d   = 1'b0;
          wb_v_d   = ~killed;
          wb_ir_d  = ir_q;
          wb_npc_d = npc_q;
          wb_alu_d = addr_q;
          wb_mem_d = (q_load && !DMEM_ERR) ? load_result : '0;
          lam_d    = 1'b0;
          sam_d    = 1'b0;
          laf_d    = ~killed & q_load & DMEM_ERR;
          saf_d    = ~killed & q_store & DMEM_ERR;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      ir_q     <= '0;
      npc_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wb_v_q   <= 1'b0;
      wb_ir_q  <= '0;
      wb_npc_q <= '0;
      wb_alu_q <= '0;
      wb_mem_q <= '0;
      lam_q    <= 1'b0;
      laf_q    <= 1'b0;
      sam_q    <= 1'b0;
      saf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      ir_q     <= ir_d;
      npc_q    <= npc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wb_v_q   <= wb_v_d;
      wb_ir_q  <= wb_ir_d;
      wb_npc_q <= wb_npc_d;
      wb_alu_q <= wb_alu_d;
      wb_mem_q <= wb_mem_d;
      lam_q    <= lam_d;
      laf_q    <= laf_d;
      sam_q    <= sam_d;
      saf_q    <= saf_d;
    end
  end

  assign WB_V          = wb_v_q;
  assign WB_IR         = wb_ir_q;
  assign WB_NPC        = wb_npc_q;
  assign WB_ALU_RESULT = wb_alu_q;
  assign WB_MEM_RESULT = wb_mem_q;
  assign MEM_LAM       = lam_q;
  assign MEM_LAF       = laf_q;
  assign MEM_SAM       = sam_q;
  assign MEM_SAF       = saf_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed ops push expected writeback records,
// an independent monitor pops and compares whenever WB_V is presented.
module tb_memory_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_V, MEM_FLUSH, MEM_STALL;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2;
  logic        DMEM_REQ, DMEM_WE, DMEM_READY, DMEM_ERR;
  logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        WB_V;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
  logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_V          (MEM_V),
    .MEM_IR         (MEM_IR),
    .MEM_NPC        (MEM_NPC),
    .MEM_ALU_RESULT (MEM_ALU_RESULT),
    .MEM_SR2        (MEM_SR2),
    .MEM_FLUSH      (MEM_FLUSH),
    .MEM_STALL      (MEM_STALL),
    .DMEM_REQ       (DMEM_REQ),
    .DMEM_WE        (DMEM_WE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_WDATA     (DMEM_WDATA),
    .DMEM_WSTRB     (DMEM_WSTRB),
    .DMEM_READY     (DMEM_READY),
    .DMEM_RDATA     (DMEM_RDATA),
    .DMEM_ERR       (DMEM_ERR),
    .WB_V           (WB_V),
    .WB_IR          (WB_IR),
    .WB_NPC         (WB_NPC),
    .WB_ALU_RESULT  (WB_ALU_RESULT),
    .WB_MEM_RESULT  (WB_MEM_RESULT),
    .MEM_LAM        (MEM_LAM),
    .MEM_LAF        (MEM_LAF),
    .MEM_SAM        (MEM_SAM),
    .MEM_SAF        (MEM_SAF)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] alu;
    logic [63:0] mem;
    logic        lam;
    logic        laf;
    logic        sam;
    logic        saf;
  } wb_t;

  wb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'd1, op};
  endfunction

  function automatic logic [63:0] npc_of(input logic [63:0] alu);
    return 64'h8000_0000 + alu;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] mem,
                      input logic lam, input logic laf, input logic sam, input logic saf);
    wb_t e;
    e.ir = ir; e.npc = npc_of(alu); e.alu = alu; e.mem = mem;
    e.lam = lam; e.laf = laf; e.sam = sam; e.saf = saf;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented writeback must match the oldest expected record.
  initial begin
    wb_t g, e;
    forever begin
      @(posedge CLK);
      #1;
      if (WB_V === 1'b1) begin
        g = '{WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected got ir=%h alu=%h mem=%h exp none", g.ir, g.alu, g.mem);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            failures++;
            $display("FAIL wb_record got ir=%h npc=%h alu=%h mem=%h f=%b%b%b%b exp ir=%h npc=%h alu=%h mem=%h f=%b%b%b%b",
                     g.ir, g.npc, g.alu, g.mem, g.lam, g.laf, g.sam, g.saf,
                     e.ir, e.npc, e.alu, e.mem, e.lam, e.laf, e.sam, e.saf);
          end
        end
      end
    end
  end

  // Issues one op and plays memory: READY after `waits` BUSY cycles, FLUSH in cycle flush_at.
  task automatic run_op(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sr2,
                        input int waits, input logic [63:0] rdata, input logic err,
                        input int flush_at, output int stall, output int reqs,
                        output logic [63:0] a, output logic [63:0] wd, output logic [7:0] ws,
                        output logic we);
    int busy_n;
    bit done;
    stall = 0; reqs = 0; a = '0; wd = '0; ws = '0; we = 1'b0; busy_n = 0; done = 1'b0;
    @(negedge CLK);
    MEM_V = 1'b1; MEM_IR = ir; MEM_NPC = npc_of(alu); MEM_ALU_RESULT = alu; MEM_SR2 = sr2;
    for (int c = 0; c < 64 && !done; c++) begin
      MEM_FLUSH = (c == flush_at);
      #1;
      if (DMEM_REQ === 1'b1) begin
        reqs++;
        a = DMEM_ADDR; wd = DMEM_WDATA; ws = DMEM_WSTRB; we = DMEM_WE;
        if (busy_n == waits) begin
          DMEM_READY = 1'b1; DMEM_RDATA = rdata; DMEM_ERR = err;
        end
        busy_n++;
      end
      #1;
      if (MEM_STALL === 1'b1) stall++;
      else done = 1'b1;
      @(negedge CLK);
      DMEM_READY = 1'b0; DMEM_ERR = 1'b0; DMEM_RDATA = '0;
    end
    chk("op_completes", {63'b0, done}, 64'd1);
    MEM_V = 1'b0; MEM_FLUSH = 1'b0;
  endtask

  initial begin
    int          st, rq;
    logic [63:0] a, wd;
    logic [7:0]  ws;
    logic        we;

    RESET = 1'b0; MEM_V = 1'b0; MEM_FLUSH = 1'b0; MEM_IR = '0; MEM_NPC = '0;
    MEM_ALU_RESULT = '0; MEM_SR2 = '0; DMEM_READY = 1'b0; DMEM_RDATA = '0; DMEM_ERR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wb_v", {63'b0, WB_V}, 64'd0);
    chk("rst_req", {63'b0, DMEM_REQ}, 64'd0);
    chk("rst_stall", {63'b0, MEM_STALL}, 64'd0);
    chk("rst_flags", {60'b0, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}, 64'd0);
    chk("rst_wb_ir", {32'b0, WB_IR}, 64'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // ADD passes straight through
    push(mk_ir(3'b000, OP_AL), 64'h1234, 64'h0, 0, 0, 0, 0);
    run_op(mk_ir(3'b000, OP_AL), 64'h1234, 64'h0, 0, 64'h0, 1'b0, -1, st, rq, a, wd, ws, we);
    chk_int("add_stall", st, 0);
    chk_int("add_req", rq, 0);

    // LB sign-extends byte 5
    push(mk_ir(3'b000, OP_LD), 64'h1005, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0, 0);
    run_op(mk_ir(3'b000, OP_LD), 64'h1005, 64'h0, 0, 64'h0000_8000_0000_0000, 1'b0, -1,
           st, rq, a, wd, ws, we);
    chk("lb_addr", a, 64'h1000);
    chk("lb_we", {63'b0, we}, 64'd0);
    chk_int("lb_stall", st, 1);

    // LBU zero-extends
    push(mk_ir(3'b100, OP_LD), 64'h1005, 64'h80, 0, 0, 0, 0);
    run_op(mk_ir(3'b100, OP_LD), 64'h1005, 64'h0, 0, 64'h0000_8000_0000_0000, 1'b0, -1,
           st, rq, a, wd, ws, we);

    // SH with three wait cycles
    push(mk_ir(3'b001, OP_ST), 64'h2006, 64'h0, 0, 0, 0, 0);
    run_op(mk_ir(3'b001, OP_ST), 64'h2006, 64'hABCD, 3, 64'h0, 1'b0, -1,
           st, rq, a, wd, ws, we);
    chk("sh_wstrb", {56'b0, ws}, 64'hC0);
    chk("sh_wdata", wd, 64'hABCD_0000_0000_0000);
    chk("sh_we", {63'b0, we}, 64'd1);
    chk_int("sh_stall", st, 4);
    chk_int("sh_req_held", rq, 4);

    // Misaligned ops pass through without a request
    push(mk_ir(3'b010, OP_LD), 64'h3002, 64'h0, 1, 0, 0, 0);
    run_op(mk_ir(3'b010, OP_LD), 64'h3002, 64'h0, 0, 64'h0, 1'b0, -1, st, rq, a, wd, ws, we);
    chk_int("lw_mis_req", rq, 0);
    chk_int("lw_mis_stall", st, 0);
    push(mk_ir(3'b011, OP_ST), 64'h3004, 64'h0, 0, 0, 1, 0);
    run_op(mk_ir(3'b011, OP_ST), 64'h3004, 64'h55, 0, 64'h0, 1'b0, -1, st, rq, a, wd, ws, we);
    chk_int("sd_mis_req", rq, 0);

    // Access faults
    push(mk_ir(3'b011, OP_LD), 64'h4000, 64'h0, 0, 1, 0, 0);
    run_op(mk_ir(3'b011, OP_LD), 64'h4000, 64'h0, 0, 64'h1111_2222_3333_4444, 1'b1, -1,
           st, rq, a, wd, ws, we);
    push(mk_ir(3'b011, OP_ST), 64'h4000, 64'h0, 0, 0, 0, 1);
    run_op(mk_ir(3'b011, OP_ST), 64'h4000, 64'hDEAD, 1, 64'h0, 1'b1, -1,
           st, rq, a, wd, ws, we);
    chk("sd_wstrb", {56'b0, ws}, 64'hFF);
    chk("sd_wdata", wd, 64'hDEAD);

    // Other sizes and lanes
    push(mk_ir(3'b001, OP_LD), 64'h4006, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0, 0);
    run_op(mk_ir(3'b001, OP_LD), 64'h4006, 64'h0, 0, 64'h8001_0000_0000_0000, 1'b0, -1,
           st, rq, a, wd, ws, we);
    push(mk_ir(3'b110, OP_LD), 64'h4004, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0);
    run_op(mk_ir(3'b110, OP_LD), 64'h4004, 64'h0, 0, 64'hFFFF_FFFF_1234_5678, 1'b0, -1,
           st, rq, a, wd, ws, we);
    push(mk_ir(3'b010, OP_ST), 64'h4004, 64'h0, 0, 0, 0, 0);
    run_op(mk_ir(3'b010, OP_ST), 64'h4004, 64'h1122_3344, 0, 64'h0, 1'b0, -1,
           st, rq, a, wd, ws, we);
    chk("sw_wstrb", {56'b0, ws}, 64'hF0);
    chk("sw_wdata", wd, 64'h1122_3344_0000_0000);

    // Flush while BUSY: request held to READY, no writeback
    run_op(mk_ir(3'b011, OP_LD), 64'h4800, 64'h0, 2, 64'h1, 1'b0, 1, st, rq, a, wd, ws, we);
    chk_int("flush_busy_req_held", rq, 3);
    chk_int("flush_busy_stall", st, 3);

    // Flush in IDLE: no request, no writeback
    run_op(mk_ir(3'b011, OP_LD), 64'h4900, 64'h0, 0, 64'h1, 1'b0, 0, st, rq, a, wd, ws, we);
    chk_int("flush_idle_req", rq, 0);

    // ADD after the memory ops still flows
    push(mk_ir(3'b000, OP_AL), 64'hCAFE, 64'h0, 0, 0, 0, 0);
    run_op(mk_ir(3'b000, OP_AL), 64'hCAFE, 64'h0, 0, 64'h0, 1'b0, -1, st, rq, a, wd, ws, we);

    repeat (3) @(posedge CLK);
    #1;
    chk_int("scoreboard_drained", exp_q.size(), 0);

    // Reset asserted mid-BUSY abandons the request
    @(negedge CLK);
    MEM_V = 1'b1; MEM_IR = mk_ir(3'b011, OP_LD); MEM_ALU_RESULT = 64'h5000;
    MEM_NPC = npc_of(64'h5000);
    @(posedge CLK);
    @(negedge CLK);
    chk("rstbusy_req_before", {63'b0, DMEM_REQ}, 64'd1);
    RESET = 1'b0; MEM_V = 1'b0;
    @(posedge CLK);
    #1;
    chk("rstbusy_req", {63'b0, DMEM_REQ}, 64'd0);
    chk("rstbusy_stall", {63'b0, MEM_STALL}, 64'd0);
    chk("rstbusy_addr", DMEM_ADDR, 64'd0);
    chk("rstbusy_wb_v", {63'b0, WB_V}, 64'd0);
    chk("rstbusy_wb_alu", WB_ALU_RESULT, 64'd0);
    chk("rstbusy_wb_npc", WB_NPC, 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
